// File: rtl/data_sram_resp_if.sv
// Data SRAM request/response bundle between the execute/memory stages and the responder.
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        resp_valid;
  logic        stallreq_for_mem;
  logic        access_err;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, resp_valid, stallreq_for_mem, access_err
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, resp_valid, stallreq_for_mem, access_err
  );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-masked word RAM with optional wait-state stall generation.
// Define DSRAM_ACCESS_CHECK_EN to enable out-of-range/misalignment checking and access_err.
module data_sram_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           resetn,
  data_sram_resp_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t             state_reg;
  logic [3:0]         cnt_reg;
  logic [ADDR_W-1:0]  word_idx;
  logic [31:0]        rd_word;
  logic               access_fire;
  logic               is_read;
  logic               acc_err;
  logic               addr_bits_unused;

  assign word_idx         = bus.data_sram_addr[ADDR_W+1:2];
  assign is_read          = (bus.data_sram_wen == 4'b0000);
  assign addr_bits_unused = ^{bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

  // Without wait states every enabled cycle is an access; otherwise only the final WAIT cycle.
  always_comb begin
    access_fire = 1'b0;
    if (WAIT_CYCLES == 0)
      access_fire = bus.data_sram_en;
    else
      access_fire = (state_reg == ST_WAIT) && (cnt_reg == 4'd0) && bus.data_sram_en;
  end

  assign bus.stallreq_for_mem = (WAIT_CYCLES != 0) &&
                                (((state_reg == ST_IDLE) && bus.data_sram_en) ||
                                 ((state_reg == ST_WAIT) && (cnt_reg != 4'd0)));

`ifdef DSRAM_ACCESS_CHECK_EN
  logic out_of_range;
  logic misaligned;
  always_comb begin
    out_of_range = |bus.data_sram_addr[31:ADDR_W+2];
    misaligned   = ((bus.data_sram_wen == 4'b1111) && (bus.data_sram_addr[1:0] != 2'b00)) ||
                   (((bus.data_sram_wen == 4'b0011) || (bus.data_sram_wen == 4'b1100)) &&
                    bus.data_sram_addr[0]);
    acc_err      = out_of_range | misaligned;
  end
`else
  assign acc_err = 1'b0;
`endif

  // One RAM per byte lane so each lane write enable maps onto its own memory.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [2**ADDR_W];

      always_ff @(posedge clk) begin
        if (access_fire && !acc_err && bus.data_sram_wen[gi])
          lane_mem[word_idx] <= bus.data_sram_wdata[8*gi +: 8];
      end

      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg           <= ST_IDLE;
      cnt_reg             <= 4'd0;
      bus.data_sram_rdata <= 32'd0;
      bus.resp_valid      <= 1'b0;
      bus.access_err      <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      if (access_fire && is_read) begin
        bus.resp_valid      <= 1'b1;
        bus.data_sram_rdata <= acc_err ? 32'd0 : rd_word;
      end
      if (access_fire && acc_err)
        bus.access_err <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if ((WAIT_CYCLES != 0) && bus.data_sram_en) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          // A dropped request is abandoned; otherwise count down to the access edge.
          if (!bus.data_sram_en || (cnt_reg == 4'd0))
            state_reg <= ST_IDLE;
          else
            cnt_reg <= cnt_reg - 4'd1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: one zero-wait instance and one three-wait-state instance.
module tb_data_sram_resp;

`ifdef DSRAM_ACCESS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_sram_resp_if if0();
  data_sram_resp_if if3();

  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) dut3 (.clk(clk), .resetn(resetn), .bus(if3));

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Drive a request at the falling edge, then settle so the sample sees this cycle.
  task automatic drv0(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    @(negedge clk);
    if0.data_sram_en    = en;
    if0.data_sram_wen   = wen;
    if0.data_sram_addr  = addr;
    if0.data_sram_wdata = wdata;
    if (en) $display("dut0 req wen=%b addr=%h wdata=%h", wen, addr, wdata);
    #1;
  endtask

  task automatic drv3(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    @(negedge clk);
    if3.data_sram_en    = en;
    if3.data_sram_wen   = wen;
    if3.data_sram_addr  = addr;
    if3.data_sram_wdata = wdata;
    if (en) $display("dut3 req wen=%b addr=%h wdata=%h", wen, addr, wdata);
    #1;
  endtask

  // Hold a request on dut3 until stall drops; leaves the bench in the access cycle.
  task automatic req3(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                      output int stalls, output int early_resp);
    drv3(1'b1, wen, addr, wdata);
    stalls     = 0;
    early_resp = 0;
    for (int k = 0; k < 20; k++) begin
      if (if3.resp_valid) early_resp++;
      if (!if3.stallreq_for_mem) break;
      stalls++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    if0.data_sram_en = 1'b0; if0.data_sram_wen = 4'h0; if0.data_sram_addr = '0; if0.data_sram_wdata = '0;
    if3.data_sram_en = 1'b0; if3.data_sram_wen = 4'h0; if3.data_sram_addr = '0; if3.data_sram_wdata = '0;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({if0.data_sram_rdata, if0.resp_valid, if0.stallreq_for_mem, if0.access_err} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dut0 got rdata=%h rv=%b st=%b err=%b exp all zero",
               if0.data_sram_rdata, if0.resp_valid, if0.stallreq_for_mem, if0.access_err);
    end
    checks++;
    if ({if3.data_sram_rdata, if3.resp_valid, if3.stallreq_for_mem, if3.access_err} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dut3 got rdata=%h rv=%b st=%b err=%b exp all zero",
               if3.data_sram_rdata, if3.resp_valid, if3.stallreq_for_mem, if3.access_err);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    drv0(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    checks++;
    if (if0.stallreq_for_mem !== 1'b0) begin
      errors++; $display("FAIL wr_stall got %b exp 0", if0.stallreq_for_mem);
    end
    drv0(1'b1, 4'h0, 32'h10, 32'h0);
    checks++;
    if (if0.resp_valid !== 1'b0 || if0.data_sram_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_no_resp got rv=%b rdata=%h exp rv=0 rdata=0",
                         if0.resp_valid, if0.data_sram_rdata);
    end
    checks++;
    if (if0.stallreq_for_mem !== 1'b0) begin
      errors++; $display("FAIL rd_stall got %b exp 0", if0.stallreq_for_mem);
    end
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if0.data_sram_rdata !== 32'hDEADBEEF || if0.resp_valid !== 1'b1) begin
      errors++; $display("FAIL rd_data got rdata=%h rv=%b exp deadbeef rv=1",
                         if0.data_sram_rdata, if0.resp_valid);
    end
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if0.data_sram_rdata !== 32'hDEADBEEF || if0.resp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_hold got rdata=%h rv=%b exp deadbeef rv=0",
                         if0.data_sram_rdata, if0.resp_valid);
    end
  endtask

  task automatic test_byte_lanes();
    drv0(1'b1, 4'hF, 32'h20, 32'h00000000);
    drv0(1'b1, 4'h4, 32'h20, 32'h12AB3456);
    drv0(1'b1, 4'h1, 32'h20, 32'h778899CD);
    drv0(1'b1, 4'h0, 32'h20, 32'h0);
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if0.data_sram_rdata !== 32'h00AB00CD || if0.resp_valid !== 1'b1) begin
      errors++; $display("FAIL byte_lanes got rdata=%h rv=%b exp 00ab00cd rv=1",
                         if0.data_sram_rdata, if0.resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    drv0(1'b1, 4'hF, 32'h0, 32'd1);
    drv0(1'b1, 4'hF, 32'h4, 32'd2);
    drv0(1'b1, 4'hF, 32'h8, 32'd3);
    drv0(1'b1, 4'h0, 32'h0, 32'h0);
    drv0(1'b1, 4'h0, 32'h4, 32'h0);
    checks++;
    if (if0.data_sram_rdata !== 32'd1 || if0.resp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_0 got rdata=%h rv=%b exp 1 rv=1", if0.data_sram_rdata, if0.resp_valid);
    end
    drv0(1'b1, 4'h0, 32'h8, 32'h0);
    checks++;
    if (if0.data_sram_rdata !== 32'd2 || if0.resp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_1 got rdata=%h rv=%b exp 2 rv=1", if0.data_sram_rdata, if0.resp_valid);
    end
    drv0(1'b1, 4'h0, 32'h6, 32'h0);
    checks++;
    if (if0.data_sram_rdata !== 32'd3 || if0.resp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_2 got rdata=%h rv=%b exp 3 rv=1", if0.data_sram_rdata, if0.resp_valid);
    end
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if0.data_sram_rdata !== 32'd2 || if0.resp_valid !== 1'b1) begin
      errors++; $display("FAIL low_bits_ignored got rdata=%h rv=%b exp 2 rv=1",
                         if0.data_sram_rdata, if0.resp_valid);
    end
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if0.resp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end got rv=%b exp 0", if0.resp_valid);
    end
  endtask

  task automatic test_wait_read();
    int stalls;
    int early;
    req3(4'hF, 32'h10, 32'hDEADBEEF, stalls, early);
    checks++;
    if (stalls != 3) begin
      errors++; $display("FAIL wait_wr_stalls got %0d exp 3", stalls);
    end
    drv3(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if3.resp_valid !== 1'b0 || if3.data_sram_rdata !== 32'h0) begin
      errors++; $display("FAIL wait_wr_no_resp got rv=%b rdata=%h exp rv=0 rdata=0",
                         if3.resp_valid, if3.data_sram_rdata);
    end
    req3(4'h0, 32'h10, 32'h0, stalls, early);
    checks++;
    if (stalls != 3 || early != 0) begin
      errors++; $display("FAIL wait_rd_stalls got stalls=%0d early=%0d exp 3 and 0", stalls, early);
    end
    drv3(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if3.data_sram_rdata !== 32'hDEADBEEF || if3.resp_valid !== 1'b1) begin
      errors++; $display("FAIL wait_rd_data got rdata=%h rv=%b exp deadbeef rv=1",
                         if3.data_sram_rdata, if3.resp_valid);
    end
    drv3(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if3.resp_valid !== 1'b0) begin
      errors++; $display("FAIL wait_rd_one_pulse got rv=%b exp 0", if3.resp_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    int stalls;
    int early;
    drv3(1'b1, 4'h0, 32'h10, 32'h0);
    checks++;
    if (if3.stallreq_for_mem !== 1'b1) begin
      errors++; $display("FAIL rst_wait_st1 got %b exp 1", if3.stallreq_for_mem);
    end
    @(negedge clk);
    #1;
    checks++;
    if (if3.stallreq_for_mem !== 1'b1) begin
      errors++; $display("FAIL rst_wait_st2 got %b exp 1", if3.stallreq_for_mem);
    end
    resetn = 1'b0;
    if3.data_sram_en = 1'b0;
    #1;
    checks++;
    if (if3.stallreq_for_mem !== 1'b0 || if3.data_sram_rdata !== 32'h0 || if3.resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wait_async got st=%b rdata=%h rv=%b exp 0 0 0",
                         if3.stallreq_for_mem, if3.data_sram_rdata, if3.resp_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if (if3.stallreq_for_mem !== 1'b0 || if3.data_sram_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_wait_release got st=%b rdata=%h exp 0 0",
                         if3.stallreq_for_mem, if3.data_sram_rdata);
    end
    req3(4'h0, 32'h10, 32'h0, stalls, early);
    drv3(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (stalls != 3 || if3.data_sram_rdata !== 32'hDEADBEEF || if3.resp_valid !== 1'b1) begin
      errors++; $display("FAIL rst_ram_kept got stalls=%0d rdata=%h rv=%b exp 3 deadbeef 1",
                         stalls, if3.data_sram_rdata, if3.resp_valid);
    end
  endtask

  task automatic test_abandon();
    int stalls;
    int early;
    drv3(1'b1, 4'hF, 32'h10, 32'h0BAD0BAD);
    @(negedge clk);
    #1;
    drv3(1'b0, 4'h0, 32'h0, 32'h0);
    drv3(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if3.stallreq_for_mem !== 1'b0 || if3.resp_valid !== 1'b0) begin
      errors++; $display("FAIL abandon_idle got st=%b rv=%b exp 0 0", if3.stallreq_for_mem, if3.resp_valid);
    end
    req3(4'h0, 32'h10, 32'h0, stalls, early);
    drv3(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if3.data_sram_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL abandon_no_write got rdata=%h exp deadbeef", if3.data_sram_rdata);
    end
  endtask

  task automatic test_access_check();
    drv0(1'b1, 4'hF, 32'h00001000, 32'hCAFEF00D);
    drv0(1'b1, 4'h0, 32'h00000002, 32'h0);
    checks++;
    if (if0.access_err !== CHK) begin
      errors++; $display("FAIL chk_err_set got %b exp %b", if0.access_err, CHK);
    end
    drv0(1'b1, 4'h0, 32'h00001000, 32'h0);
    checks++;
    if (if0.data_sram_rdata !== (CHK ? 32'd1 : 32'hCAFEF00D) || if0.resp_valid !== 1'b1) begin
      errors++; $display("FAIL chk_word0 got rdata=%h rv=%b exp %h rv=1",
                         if0.data_sram_rdata, if0.resp_valid, CHK ? 32'd1 : 32'hCAFEF00D);
    end
    drv0(1'b1, 4'hF, 32'h00000009, 32'h99999999);
    checks++;
    if (if0.data_sram_rdata !== (CHK ? 32'd0 : 32'hCAFEF00D) || if0.resp_valid !== 1'b1) begin
      errors++; $display("FAIL chk_oor_read got rdata=%h rv=%b exp %h rv=1",
                         if0.data_sram_rdata, if0.resp_valid, CHK ? 32'd0 : 32'hCAFEF00D);
    end
    drv0(1'b1, 4'h0, 32'h00000008, 32'h0);
    checks++;
    if (if0.resp_valid !== 1'b0 || if0.access_err !== CHK) begin
      errors++; $display("FAIL chk_misalign_wr got rv=%b err=%b exp rv=0 err=%b",
                         if0.resp_valid, if0.access_err, CHK);
    end
    drv0(1'b0, 4'h0, 32'h0, 32'h0);
    checks++;
    if (if0.data_sram_rdata !== (CHK ? 32'd3 : 32'h99999999) || if0.access_err !== CHK) begin
      errors++; $display("FAIL chk_word2 got rdata=%h err=%b exp %h err=%b",
                         if0.data_sram_rdata, if0.access_err, CHK ? 32'd3 : 32'h99999999, CHK);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_wait_read();
    test_reset_mid_wait();
    test_abandon();
    test_access_check();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
